// File: rtl/char_buf_arbiter.sv
// char_buf_arbiter: 256x8 character-code buffer for the text overlay.
// A free-running registered read port serves the display every cycle.
// Two writers (A, B) share one write port through a round-robin
// valid/grant handshake. A clear sequence fills the buffer with CLEAR_CHAR
// after reset and whenever clr_req is seen while idle.
// Optional build macro: CHAR_BUF_AUTOINC_EN. When it is defined, requester A
// writes through an internal {col,row} cursor and a_xy is ignored.
module char_buf_arbiter #(
  parameter int         COLS       = 16,
  parameter int         ROWS       = 16,
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rd_xy,
  output logic [7:0] rd_code,
  input  logic       a_req,
  input  logic [7:0] a_xy,
  input  logic [7:0] a_code,
  output logic       a_gnt,
  input  logic       b_req,
  input  logic [7:0] b_xy,
  input  logic [7:0] b_code,
  output logic       b_gnt,
  input  logic       clr_req,
  output logic       busy
);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  localparam logic [4:0] COLS_L = 5'(COLS);
  localparam logic [4:0] ROWS_L = 5'(ROWS);

  state_t     state_q, state_d;
  logic [7:0] clr_addr_q, clr_addr_d;
  logic       rr_last_b_q, rr_last_b_d;  // 1 when B held the most recent grant
  logic [7:0] rd_code_q;
  logic [7:0] mem [256];

  logic       we;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       clr_start;
  logic [7:0] a_addr;

  // Off-screen writes still complete the handshake but leave the buffer alone.
  function automatic logic in_bounds(input logic [7:0] xy);
    return ({1'b0, xy[7:4]} < COLS_L) && ({1'b0, xy[3:0]} < ROWS_L);
  endfunction

`ifdef CHAR_BUF_AUTOINC_EN
  localparam logic [3:0] COL_MAX = 4'(COLS - 1);
  localparam logic [3:0] ROW_MAX = 4'(ROWS - 1);

  logic [3:0] cur_col_q, cur_col_d;
  logic [3:0] cur_row_q, cur_row_d;
  logic       unused_a_xy;

  assign unused_a_xy = ^a_xy;
  assign a_addr      = {cur_col_q, cur_row_q};

  // Cursor steps row-major after each granted A write and homes on a clear.
  always_comb begin
    cur_col_d = cur_col_q;
    cur_row_d = cur_row_q;
    if (clr_start) begin
      cur_col_d = '0;
      cur_row_d = '0;
    end else if (a_gnt) begin
      if (cur_col_q == COL_MAX) begin
        cur_col_d = '0;
        cur_row_d = (cur_row_q == ROW_MAX) ? 4'd0 : cur_row_q + 4'd1;
      end else begin
        cur_col_d = cur_col_q + 4'd1;
      end
    end
  end

  // Cursor register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_col_q <= '0;
      cur_row_q <= '0;
    end else begin
      cur_col_q <= cur_col_d;
      cur_row_q <= cur_row_d;
    end
  end
`else
  assign a_addr = a_xy;
`endif

  // Clear sequencing, arbitration and write-port mux.
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    rr_last_b_d = rr_last_b_q;
    a_gnt       = 1'b0;
    b_gnt       = 1'b0;
    busy        = 1'b0;
    clr_start   = 1'b0;
    we          = 1'b0;
    wr_addr     = clr_addr_q;
    wr_data     = CLEAR_CHAR;
    if (rst) begin
      busy = 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          busy       = 1'b1;
          we         = 1'b1;
          clr_addr_d = clr_addr_q + 8'd1;
          if (clr_addr_q == 8'hFF) state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (clr_req) begin
            // A clear request outranks any pending write this cycle.
            state_d    = ST_CLEAR;
            clr_addr_d = '0;
            clr_start  = 1'b1;
          end else if (a_req && (!b_req || rr_last_b_q)) begin
            a_gnt       = 1'b1;
            rr_last_b_d = 1'b0;
            wr_addr     = a_addr;
            wr_data     = a_code;
            we          = in_bounds(a_addr);
          end else if (b_req) begin
            b_gnt       = 1'b1;
            rr_last_b_d = 1'b1;
            wr_addr     = b_xy;
            wr_data     = b_code;
            we          = in_bounds(b_xy);
          end
        end
        default: state_d = ST_CLEAR;
      endcase
    end
  end

  // State, clear pointer and round-robin history; reset favours A first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clr_addr_q  <= '0;
      rr_last_b_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      rr_last_b_q <= rr_last_b_d;
    end
  end

  // Buffer write port; contents are initialised by the clear sequence only.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Display read port: registered, returns pre-write data on a collision.
  always_ff @(posedge clk) begin
    if (rst) rd_code_q <= '0;
    else     rd_code_q <= mem[rd_xy];
  end

  assign rd_code = rd_code_q;

endmodule

// File: tb/tb_char_buf_arbiter.sv
// Self-checking bench for char_buf_arbiter: directed steps plus a random
// phase, all compared cycle by cycle against a behavioural buffer model.
module tb_char_buf_arbiter;

`ifdef CHAR_BUF_AUTOINC_EN
  localparam int TB_COLS = 16;
`else
  localparam int TB_COLS = 10;
`endif
  localparam int         TB_ROWS = 16;
  localparam logic [7:0] CLR     = 8'h20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rd_xy;
  logic [7:0] rd_code;
  logic       a_req, b_req, clr_req;
  logic [7:0] a_xy, a_code, b_xy, b_code;
  logic       a_gnt, b_gnt, busy;

  always #5 clk = ~clk;

  char_buf_arbiter #(.COLS(TB_COLS), .ROWS(TB_ROWS), .CLEAR_CHAR(CLR)) dut (
    .clk(clk), .rst(rst), .rd_xy(rd_xy), .rd_code(rd_code),
    .a_req(a_req), .a_xy(a_xy), .a_code(a_code), .a_gnt(a_gnt),
    .b_req(b_req), .b_xy(b_xy), .b_code(b_code), .b_gnt(b_gnt),
    .clr_req(clr_req), .busy(busy)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model: buffer image, remaining clear writes, fairness, cursor.
  logic [7:0] m_mem   [256];
  bit         m_valid [256];
  int         clear_left = 0;
  bit         last_a     = 1'b0;
  int         cur_idx    = 0;

  bit got_a, got_b;   // model grants of the last cycle
  bit obs_a, obs_b;   // DUT grants seen in the last cycle

  logic [7:0] probe   [3] = '{8'h00, 8'h7A, 8'hFF};
  logic [7:0] ca_xy   [2] = '{8'h01, 8'h02};
  logic [7:0] ca_code [2] = '{8'h41, 8'h42};
  logic [7:0] cb_xy   [2] = '{8'h03, 8'h04};
  logic [7:0] cb_code [2] = '{8'h61, 8'h62};
  int         ia, ib, n;
  logic [3:0] pat;

  function automatic bit on_screen(logic [7:0] xy);
    return (int'(xy[7:4]) < TB_COLS) && (int'(xy[3:0]) < TB_ROWS);
  endfunction

  // Address an A write actually targets.
  function automatic logic [7:0] a_target();
`ifdef CHAR_BUF_AUTOINC_EN
    return 8'(((cur_idx % TB_COLS) << 4) | (cur_idx / TB_COLS));
`else
    return a_xy;
`endif
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict, check combinational outputs, advance model, check read.
  task automatic cycle();
    bit         eg_a, eg_b, eb, rd_known;
    logic [7:0] e_rd, a_t;
    eg_a = 1'b0;
    eg_b = 1'b0;
    a_t  = a_target();
    eb   = rst || (clear_left != 0);
    if (!eb && !clr_req) begin
      if (a_req && b_req) begin
        if (last_a) eg_b = 1'b1;
        else        eg_a = 1'b1;
      end else if (a_req) eg_a = 1'b1;
      else if (b_req)     eg_b = 1'b1;
    end
    @(negedge clk);
    obs_a = a_gnt;
    obs_b = b_gnt;
    chk("busy",  32'(busy),  32'(eb));
    chk("a_gnt", 32'(a_gnt), 32'(eg_a));
    chk("b_gnt", 32'(b_gnt), 32'(eg_b));
    if (rst) begin
      e_rd = 8'h00; rd_known = 1'b1;
    end else begin
      e_rd = m_mem[rd_xy]; rd_known = m_valid[rd_xy];
    end
    if (rst) begin
      clear_left = 256; last_a = 1'b0; cur_idx = 0;
    end else if (clear_left != 0) begin
      m_mem[256 - clear_left]   = CLR;
      m_valid[256 - clear_left] = 1'b1;
      clear_left--;
    end else if (clr_req) begin
      clear_left = 256; cur_idx = 0;
    end else if (eg_a) begin
      if (on_screen(a_t)) begin m_mem[a_t] = a_code; m_valid[a_t] = 1'b1; end
      last_a  = 1'b1;
      cur_idx = (cur_idx + 1) % (TB_COLS * TB_ROWS);
    end else if (eg_b) begin
      if (on_screen(b_xy)) begin m_mem[b_xy] = b_code; m_valid[b_xy] = 1'b1; end
      last_a = 1'b0;
    end
    got_a = eg_a;
    got_b = eg_b;
    @(posedge clk);
    #1;
    if (rd_known) chk("rd_code", 32'(rd_code), 32'(e_rd));
  endtask

  initial begin
    rst = 1'b1; rd_xy = '0; clr_req = 1'b0;
    a_req = 1'b0; a_xy = '0; a_code = '0;
    b_req = 1'b0; b_xy = '0; b_code = '0;

    // Reset, part of a clear, a mid-clear reset, then a full clear.
    repeat (3) cycle();
    rst = 1'b0;
    repeat (100) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      rd_xy = probe[i % 3];
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      rd_xy = probe[i];
      cycle();
    end

    // Sustained contention straight after reset: A wins first, then alternates.
    ia = 0; ib = 0; pat = '0;
    a_req = 1'b1; a_xy = ca_xy[0]; a_code = ca_code[0];
    b_req = 1'b1; b_xy = cb_xy[0]; b_code = cb_code[0];
    for (int i = 0; i < 4; i++) begin
      cycle();
      pat = {pat[2:0], obs_a};
      if (got_a && ia < 1) begin ia++; a_xy = ca_xy[ia]; a_code = ca_code[ia]; end
      if (got_b && ib < 1) begin ib++; b_xy = cb_xy[ib]; b_code = cb_code[ib]; end
    end
    a_req = 1'b0; b_req = 1'b0;
    chk("contention_order", 32'(pat), 32'(4'b1010));
    for (int i = 0; i < 2; i++) begin rd_xy = ca_xy[i]; cycle(); end
    for (int i = 0; i < 2; i++) begin rd_xy = cb_xy[i]; cycle(); end

    // Single write then read back.
    a_req = 1'b1; a_xy = 8'h53; a_code = 8'h41;
    cycle();
    chk("single_gnt", 32'(obs_a), 32'd1);
    a_req = 1'b0; rd_xy = 8'h53;
    cycle();

    // Clear beats a pending write; the write lands once the clear is over.
    a_req = 1'b1; a_xy = 8'h12; a_code = 8'h5A; clr_req = 1'b1;
    cycle();
    chk("clr_prio_gnt", 32'(obs_a), 32'd0);
    clr_req = 1'b0;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!obs_a && n < 400);
    a_req = 1'b0;
    chk("clr_gnt_delay", 32'(n), 32'd257);
    rd_xy = 8'h12;
    cycle();

    // Off-screen B write: handshake completes, buffer untouched.
    b_req = 1'b1; b_xy = 8'hA2; b_code = 8'h55;
    cycle();
    chk("bounds_gnt", 32'(obs_b), 32'd1);
    b_req = 1'b0; rd_xy = 8'hA2;
    cycle();

    // Read-before-write on a colliding address.
    rd_xy = 8'h11; a_req = 1'b1; a_xy = 8'h11; a_code = 8'h30;
    cycle();
    a_req = 1'b0;
    cycle();

    // 257 back-to-back A writes (wraps the cursor when it exists).
    a_req = 1'b1;
    for (int i = 0; i < 257; i++) begin
      a_xy = 8'($urandom); a_code = 8'($urandom); rd_xy = 8'($urandom);
      cycle();
    end
    a_req = 1'b0; rd_xy = 8'h00;
    cycle();

    // Random traffic; requesters hold each request until it is granted.
    for (int i = 0; i < 600; i++) begin
      if (!a_req || got_a) begin
        a_req = 1'($urandom_range(0, 1)); a_xy = 8'($urandom); a_code = 8'($urandom);
      end
      if (!b_req || got_b) begin
        b_req = 1'($urandom_range(0, 1)); b_xy = 8'($urandom); b_code = 8'($urandom);
      end
      clr_req = ($urandom_range(0, 63) == 0);
      rd_xy   = 8'($urandom);
      cycle();
    end
    clr_req = 1'b0; a_req = 1'b0; b_req = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
